cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle program sequencer for the 8-register, 8-bit datapath and its 20-bit instruction decoder. Owns the program counter and instruction register, fetches 16-bit instructions from instruction memory over a request/ready handshake, and presents each one to the decoder. Issues a one-cycle execute strobe that qualifies register-file and data-memory writes, then computes the next PC from the decoder's branch bits and the datapath N/Z flags. Sits between instruction memory and the decoder/datapath/DMEM top level.

## Interface
- PC_W, 8, program-counter and instruction-memory address width
- HALT_OP, 7'h7F, opcode value in instruction[15:9] that stops the sequencer
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begins execution from PC 0 when in IDLE or HALT; ignored otherwise
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address, equal to PC
- imem_ready  in  1  instruction memory has valid imem_data this cycle
- imem_data  in  16  fetched instruction
- instruction  out  16  instruction register, drives the decoder
- control  in  20  decoder output; bit 2 PL (branch enable), bit 1 JB (1 = jump, 0 = conditional), bit 0 BC (0 = test Z, 1 = test N)
- addr_a  in  8  datapath A-bus value (Address_out), used as jump target
- N, Z  in  1  datapath flags for the current instruction
- exec_en  out  1  execute strobe; top level ANDs it into RW (control[4]) and MW (control[3])
- PC  out  PC_W  program counter
- state  out  2  IDLE=0, FETCH=1, EXEC=2, HALT=3
- halted  out  1  high in HALT
- instret  out  16  retired-instruction counter

## Operation
- IDLE: all strobes low. On start, load PC=0 and go to FETCH.
- FETCH: imem_req=1, imem_addr=PC. Both stay stable until imem_ready is sampled high. On that edge, load instruction<=imem_data and go to EXEC.
- EXEC: exec_en=1 for exactly one cycle, and imem_req=0. At the end of the cycle:
  - instret increments by 1; 16-bit modulo, 0xFFFF -> 0x0000.
  - If instruction[15:9]==HALT_OP: PC is not updated, go to HALT. The HALT instruction is retired, but its PL bit is ignored.
  - Else if PL=1 and JB=1: PC<=addr_a[PC_W-1:0].
  - Else if PL=1 and JB=0, and the condition holds (Z when BC=0, N when BC=1): PC<=PC+sext({instruction[8:6],instruction[2:0]}). The offset is 6-bit two's complement, so -32..+31.
  - Otherwise: PC<=PC+1.
  - All PC arithmetic is modulo 2^PC_W: 0xFF+1 -> 0x00, and 0x02+(-4) -> 0xFE.
  - Go to FETCH.
- HALT: halted=1; PC, instruction and instret hold. On start, clear halted, set PC=0, go to FETCH. instret is not cleared.
- start is ignored in FETCH and EXEC.
- N, Z and addr_a are sampled only at the EXEC edge, and are combinational from the datapath for the current instruction.

## Timing
- Reset values, applied immediately and asynchronously (including mid-fetch or mid-exec):
  - state=IDLE, PC=0, instruction=16'h0000, instret=0
  - imem_req=0, exec_en=0, halted=0
  - imem_addr follows PC
- Minimum instruction period is 2 cycles: one FETCH cycle with imem_ready already high, then one EXEC cycle.
- Each wait cycle adds one cycle. There is no timeout.
- imem_req is registered-state-decoded, with no combinational path from imem_ready.
- exec_en is never high in the same cycle as imem_req.
- The new PC is visible the cycle after EXEC, together with the next imem_req.
- If rst is released while start is high, start is honoured on the first rising edge after release.

## Test plan
- Reset then start, with imem_ready tied high, fetching 3 non-branch instructions:
  - exec_en pulses on cycles 3, 5 and 7 after start.
  - PC goes 0 -> 1 -> 2 -> 3.
  - instret=3.
- Wait states: hold imem_ready low for 4 cycles in FETCH.
  - imem_req and imem_addr stay stable throughout, and exec_en stays 0.
  - instruction loads on the ready cycle.
- Conditional branch at PC=0x10 with offset field 6'b111100 (-4) and BC=0:
  - With Z=1: next PC=0x0C.
  - With Z=0: next PC=0x11.
  - Repeat with BC=1 and N, and with offset +31 from PC=0xF0, which gives 0x0F (wrap).
- Jump with PL=1, JB=1, addr_a=0x5A: next PC=0x5A. Also check that PC 0xFF with no branch wraps to 0x00.
- HALT_OP fetched at PC=0x07:
  - halted=1, PC stays 0x07, instret increments once, then no further imem_req.
  - start then restarts with PC=0 and instret preserved.
- Assert rst during EXEC: all outputs return to their reset values before the next clock edge, and no further exec_en occurs until start.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute sequencer owning PC, instruction register and retired-instruction count
module cpu_sequencer #(
  parameter int PC_W = 8,
  parameter logic [6:0] HALT_OP = 7'h7F
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [15:0]     imem_data,
  output logic [15:0]     instruction,
  input  logic [19:0]     control,
  input  logic [7:0]      addr_a,
  input  logic            N,
  input  logic            Z,
  output logic            exec_en,
  output logic [PC_W-1:0] PC,
  output logic [1:0]      state,
  output logic            halted,
  output logic [15:0]     instret
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
  state_t st;
  logic [PC_W-1:0] off;
  logic [PC_W-1:0] next_pc;
  logic taken;
  logic unused;
  assign off = {{(PC_W-6){instruction[8]}}, instruction[8:6], instruction[2:0]};
  assign taken = control[2] & (control[1] | (control[0] ? N : Z));
  assign next_pc = !taken ? PC + 1'b1 : control[1] ? PC_W'(addr_a) : PC + off;
  assign unused = ^control[19:3];
  assign state = st;
  assign imem_req = st == FETCH;
  assign exec_en = st == EXEC;
  assign halted = st == HALT;
  assign imem_addr = PC;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      PC <= '0;
      instruction <= '0;
      instret <= '0;
    end else
      case (st)
        IDLE, HALT:
          if (start) begin
            PC <= '0;
            st <= FETCH;
          end
        FETCH:
          if (imem_ready) begin
            instruction <= imem_data;
            st <= EXEC;
          end
        EXEC: begin
          instret <= instret + 16'd1;
          if (instruction[15:9] == HALT_OP)
            st <= HALT;
          else begin
            PC <= next_pc;
            st <= FETCH;
          end
        end
        default: st <= IDLE;
      endcase
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized scoreboard bench for cpu_sequencer against a transaction-level model
module tb_cpu_sequencer;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic imem_ready = 0;
  logic N = 0;
  logic Z = 0;
  logic [15:0] imem_data = 0;
  logic [19:0] control = 0;
  logic [7:0] addr_a = 0;
  logic imem_req, exec_en, halted;
  logic [7:0] imem_addr, PC;
  logic [15:0] instruction, instret;
  logic [1:0] state;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_data(imem_data),
    .instruction(instruction), .control(control), .addr_a(addr_a), .N(N), .Z(Z),
    .exec_en(exec_en), .PC(PC), .state(state), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    logic [15:0] instr;
    int next_pc;
    int instret;
    bit halt;
  } exp_t;

  localparam logic [15:0] HALT_I = 16'hFE00;
  localparam logic [15:0] NOP_I = 16'h1234;

  exp_t sb[$];
  logic [15:0] mem[256];
  logic [2:0] ctl[256];
  bit nf[256];
  bit zf[256];
  logic [7:0] aa[256];
  int checks = 0;
  int failures = 0;
  int m_pc = 0;
  int m_instret = 0;
  int force_wait = -1;
  int exec_cnt = 0;

  task automatic chk(string name, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Architectural next-PC rule, computed with plain integer arithmetic modulo 256.
  function automatic int model_next(int pc, logic [15:0] d, logic [2:0] c, bit n, bit z, logic [7:0] a);
    int o;
    if (d[15:9] == 7'h7F) return pc;
    if (c[2] && c[1]) return int'(a);
    if (c[2] && (c[0] ? n : z)) begin
      o = int'({d[8:6], d[2:0]});
      if (o > 31) o -= 64;
      return (pc + o + 256) % 256;
    end
    return (pc + 1) % 256;
  endfunction

  function automatic logic [15:0] mk_br(logic [5:0] o);
    return {7'h05, o[5:3], 3'b101, o[2:0]};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      mem[i] = HALT_I;
      ctl[i] = 3'b000;
      nf[i] = 0;
      zf[i] = 0;
      aa[i] = 8'h00;
    end
  endtask

  task automatic set_jump(int at, logic [7:0] target);
    mem[at] = NOP_I;
    ctl[at] = 3'b110;
    aa[at] = target;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1;
    m_pc = 0;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_halt(int bound);
    int n;
    n = 0;
    while (!halted && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!halted) begin
      checks++;
      failures++;
      $display("FAIL halt_timeout: got halted=0 required halted=1 within %0d cycles", bound);
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #2 rst = 1;
    m_pc = 0;
    m_instret = 0;
    sb.delete();
    @(negedge clk);
    #2 rst = 0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_state", state, 0);
    chk("rst_pc", PC, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_ir", instruction, 0);
    chk("rst_instret", instret, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_exec", exec_en, 0);
    chk("rst_halted", halted, 0);
  endtask

  task automatic run_branch(logic [7:0] from, logic [5:0] o, bit bc, bit flag, int exp_next);
    clear_prog();
    set_jump(0, from);
    mem[from] = mk_br(o);
    ctl[from] = {2'b10, bc};
    nf[from] = bc ? flag : !flag;
    zf[from] = bc ? !flag : flag;
    do_start();
    wait_halt(100);
    chk("branch_target", PC, exp_next);
  endtask

  // Memory responder: answers fetches with random wait states and records the expected outcome.
  initial forever begin : responder
    int w;
    logic [7:0] a;
    logic [15:0] ir;
    bit ab;
    exp_t e;
    @(negedge clk);
    if (!rst && imem_req) begin
      w = force_wait >= 0 ? force_wait : int'($urandom_range(0, 3));
      a = imem_addr;
      ir = instruction;
      ab = 0;
      for (int i = 0; i < w && !ab; i++) begin
        imem_ready = 0;
        imem_data = 16'($urandom);
        control = 20'($urandom);
        @(negedge clk);
        if (rst) ab = 1;
        else begin
          chk("wait_req", imem_req, 1);
          chk("wait_addr", imem_addr, a);
          chk("wait_ir", instruction, ir);
          chk("wait_exec", exec_en, 0);
        end
      end
      if (!ab) begin
        imem_ready = 1;
        imem_data = mem[imem_addr];
        control = {17'($urandom), ctl[imem_addr]};
        N = nf[imem_addr];
        Z = zf[imem_addr];
        addr_a = aa[imem_addr];
        @(posedge clk);
        if (!rst) begin
          e.pc = m_pc;
          e.instr = mem[m_pc];
          e.halt = mem[m_pc][15:9] == 7'h7F;
          e.next_pc = model_next(m_pc, mem[m_pc], ctl[m_pc], nf[m_pc], zf[m_pc], aa[m_pc]);
          m_instret = (m_instret + 1) % 65536;
          e.instret = m_instret;
          m_pc = e.next_pc;
          sb.push_back(e);
        end
        @(negedge clk);
        imem_ready = 0;
        imem_data = 16'($urandom);
      end
    end
  end

  exp_t cur;
  bit pending = 0;
  always @(negedge clk) begin
    if (rst) pending = 0;
    else begin
      if (pending) begin
        chk("next_pc", PC, cur.next_pc);
        chk("instret", instret, cur.instret);
        chk("halted", halted, cur.halt);
        chk("req_after_exec", imem_req, !cur.halt);
        chk("state_after_exec", state, cur.halt ? 3 : 1);
        if (!cur.halt) chk("fetch_addr", imem_addr, cur.next_pc);
        pending = 0;
      end
      if (exec_en) begin
        exec_cnt++;
        chk("exec_excl_req", imem_req, 0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_exec: got exec_en=1 required no execute (nothing fetched)");
        end else begin
          cur = sb.pop_front();
          chk("exec_pc", PC, cur.pc);
          chk("exec_ir", instruction, cur.instr);
          pending = 1;
        end
      end
    end
  end

  initial begin
    int held, n, ec;
    clear_prog();
    for (int i = 0; i < 3; i++) mem[i] = NOP_I;
    force_wait = 0;
    #2 chk_reset_vals();
    @(negedge clk);
    start = 1;
    m_pc = 0;
    #1 rst = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 2) begin
        chk("start_after_rst", state, 1);
        start = 0;
      end
      chk("exec_cycle", exec_en, (c == 3 || c == 5 || c == 7) ? 1 : 0);
    end
    wait_halt(50);
    chk("seq_pc", PC, 3);
    chk("seq_instret", instret, 4);

    force_wait = 4;
    do_start();
    wait_halt(100);
    force_wait = -1;
    chk("wait_instret", instret, 8);

    clear_prog();
    set_jump(0, 8'h07);
    do_start();
    wait_halt(100);
    chk("halt_pc", PC, 7);
    held = instret;
    repeat (5) begin
      @(negedge clk);
      chk("halt_no_req", imem_req, 0);
      chk("halt_hold", halted, 1);
      chk("halt_pc_hold", PC, 7);
      chk("halt_instret_hold", instret, held);
    end
    do_start();
    chk("restart_state", state, 1);
    chk("restart_pc", PC, 0);
    chk("restart_halted", halted, 0);
    chk("restart_instret", instret, held);
    wait_halt(100);

    run_branch(8'h10, 6'b111100, 0, 1, 8'h0C);
    run_branch(8'h10, 6'b111100, 0, 0, 8'h11);
    run_branch(8'h10, 6'b111100, 1, 1, 8'h0C);
    run_branch(8'h10, 6'b111100, 1, 0, 8'h11);
    run_branch(8'hF0, 6'b011111, 0, 1, 8'h0F);
    run_branch(8'hF0, 6'b011111, 1, 1, 8'h0F);

    clear_prog();
    set_jump(0, 8'h5A);
    do_start();
    wait_halt(100);
    chk("jump_target", PC, 8'h5A);

    clear_prog();
    set_jump(0, 8'hFF);
    mem[8'hFF] = NOP_I;
    ctl[8'hFF] = 3'b011;
    do_start();
    n = 0;
    while (!(imem_req && imem_addr == 8'hFF) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_ff", imem_addr, 8'hFF);
    mem[0] = HALT_I;
    ctl[0] = 3'b000;
    wait_halt(100);
    chk("wrap_pc", PC, 0);

    clear_prog();
    for (int i = 0; i < 3; i++) mem[i] = NOP_I;
    do_start();
    n = 0;
    while (!exec_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_exec", exec_en, 1);
    #2 rst = 1;
    m_pc = 0;
    m_instret = 0;
    sb.delete();
    #1 chk_reset_vals();
    @(negedge clk);
    #2 rst = 0;
    ec = exec_cnt;
    imem_ready = 1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_exec", exec_en, 0);
      chk("post_rst_req", imem_req, 0);
      chk("post_rst_state", state, 0);
    end
    imem_ready = 0;
    chk("post_rst_exec_cnt", exec_cnt, ec);

    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] = ($urandom_range(0, 11) == 0) ? {7'h7F, 9'($urandom)} : {7'($urandom_range(0, 126)), 9'($urandom)};
        ctl[i] = 3'($urandom);
        nf[i] = 1'($urandom);
        zf[i] = 1'($urandom);
        aa[i] = 8'($urandom);
      end
      do_start();
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (halted) do_start();
      end
      pulse_rst();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
